mux_2x1: RTL and testbench
==========================

// Module: mux_2x1
//
// PURPOSE
//   Two-input, WIDTH-bit multiplexer.
//   - Output y selects a when s=0 and b when s=1.
//   - y is purely combinational; a registered copy y_q is also provided for
//     timing-critical consumers.
//   - Leaf datapath primitive, instantiated wherever a two-way steering point
//     is needed.
//
// PARAMETERS
//   WIDTH   1   data width of a, b, y, y_q (>=1)
//
// PORTS
//   clk     in   1      rising-edge clock; used only by y_q
//   rst_n   in   1      asynchronous active-low reset; used only by y_q
//   a       in   WIDTH  data input 0, selected when s=0
//   b       in   WIDTH  data input 1, selected when s=1
//   s       in   1      select
//   y       out  WIDTH  combinational output: s ? b : a
//   y_q     out  WIDTH  registered output: y sampled on the rising edge of clk
//
// BEHAVIOUR
//   Combinational path y
//   - Zero-cycle latency; y follows any change on a, b or s within the same
//     delta cycle.
//   - No clock or reset dependency: y is valid with clk stopped and with rst_n
//     held low.
//   - s is X or Z: y = a where a==b bitwise, else X (standard ?: semantics).
//     No latch is inferred.
//   Registered path y_q
//   - rst_n=0: y_q is forced to all zeros immediately (asynchronous), without
//     waiting for clk.
//   - Reset release is synchronous in effect: the first load occurs on the
//     first rising edge of clk after rst_n=1.
//   - rst_n=1: y_q <= (s ? b : a) on each rising edge; latency is one cycle
//     relative to y.
//   - Reset asserted mid-operation: y_q clears at once, while y keeps
//     tracking the inputs.
//   Width rules
//   - All data ports are exactly WIDTH bits; no extension or truncation.
//   - Selection is bitwise-uniform: one s drives all bits.
//   Simultaneous events
//   - If a, b and s change in the same step, y reflects the new values.
//   - y_q captures the values present at the clock edge (setup respected).
//
// STRUCTURE
//   - Shared package mux_pkg holds the select constants SEL_A=1'b0 and
//     SEL_B=1'b1. These are used by RTL and bench.
//   - No sub-module. One continuous assign for y and one always block
//     (posedge clk or negedge rst_n) for y_q.
//   - Include WIDTH>=1 elaboration check.
//
// TESTING
//   1. Truth table, WIDTH=1, 10-time-unit steps, no clock running, rst_n=1.
//      Each stimulus is applied as (a,b,s) -> required y:
//        (0,0,0)->0, (0,0,1)->0, (0,1,0)->0, (1,1,1)->1, (1,0,0)->1,
//        (0,1,1)->1.
//      y must settle within the same step.
//   2. Reset
//      - Drive rst_n=0 with a=1, b=1, s=1: y_q=0 immediately, while y=1.
//      - Release rst_n, then apply one clk edge: y_q=1.
//   3. Registered latency
//      - rst_n=1, a=0, b=1. Toggle s 0->1 between edges.
//      - y changes at once; y_q changes only at the next rising edge.
//   4. Mid-operation reset
//      - With y_q=1, pulse rst_n low between clock edges: y_q drops to 0
//        before the next edge.
//      - y is unaffected.
//   5. Wide data, WIDTH=8: a=8'hA5, b=8'h3C.
//      - s=0 -> y=8'hA5; s=1 -> y=8'h3C.
//      - After one edge, y_q=8'h3C.
//   6. X-select: a=b=8'hFF, s=1'bx -> y=8'hFF.

Source files
------------

// File: rtl/mux_pkg.sv
// Select encodings shared by the two-way mux and anything that drives its select.
package mux_pkg;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux_2x1.sv
// WIDTH-bit two-input mux: combinational y plus a one-cycle registered copy y_q.
module mux_2x1
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q
);

  generate
    if (WIDTH < 1) begin : g_width_check
      $error("mux_2x1: WIDTH must be >= 1");
    end
  endgenerate

  // ?: keeps the X-select merge: bits where a==b stay known.
  assign y = (s == SEL_B) ? b : a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= '0;
    end else begin
      y_q <= y;
    end
  end

endmodule

// File: tb/tb_mux_2x1.sv
// Directed bench for mux_2x1 at WIDTH=1 and WIDTH=8.
module tb_mux_2x1;
  import mux_pkg::*;

  logic       clk = 1'b0;
  logic       clk_run = 1'b0;
  logic       rst_n = 1'b1;
  logic       s = SEL_A;
  logic       a1 = 1'b0;
  logic       b1 = 1'b0;
  logic       y1;
  logic       y_q1;
  logic [7:0] a8 = 8'h00;
  logic [7:0] b8 = 8'h00;
  logic [7:0] y8;
  logic [7:0] y_q8;

  int tests_run = 0;
  int tests_failed = 0;

  mux_2x1 #(.WIDTH(1)) dut_w1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .s(s), .y(y1), .y_q(y_q1)
  );

  mux_2x1 #(.WIDTH(8)) dut_w8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .s(s), .y(y8), .y_q(y_q8)
  );

  // Clock only toggles once enabled, so the truth table runs with clk stopped.
  always #5 if (clk_run) clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic a;
    logic b;
    logic s;
    logic y;
  } vec_t;

  vec_t tt[6];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    tt[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tt[1] = '{1'b0, 1'b0, 1'b1, 1'b0};
    tt[2] = '{1'b0, 1'b1, 1'b0, 1'b0};
    tt[3] = '{1'b1, 1'b1, 1'b1, 1'b1};
    tt[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    tt[5] = '{1'b0, 1'b1, 1'b1, 1'b1};

    // Truth table, clock stopped, reset inactive
    for (int i = 0; i < 6; i++) begin
      a1 = tt[i].a;
      b1 = tt[i].b;
      s  = tt[i].s;
      #1;
      check($sformatf("truth_%0d", i), {7'b0, y1}, {7'b0, tt[i].y});
      #9;
    end

    // Asynchronous reset with no clock edge
    a1 = 1'b1; b1 = 1'b1; s = SEL_B;
    a8 = 8'h5A; b8 = 8'hC3;
    rst_n = 1'b0;
    #1;
    check("rst_yq_w1", {7'b0, y_q1}, 8'h00);
    check("rst_yq_w8", y_q8, 8'h00);
    check("rst_y_w1", {7'b0, y1}, 8'h01);
    check("rst_y_w8", y8, 8'hC3);
    #9;
    rst_n = 1'b1;
    #1;
    check("release_no_edge", {7'b0, y_q1}, 8'h00);
    clk_run = 1'b1;
    @(posedge clk); #1;
    check("first_load_w1", {7'b0, y_q1}, 8'h01);
    check("first_load_w8", y_q8, 8'hC3);

    // Registered latency: s toggles between edges
    @(negedge clk);
    a1 = 1'b0; b1 = 1'b1; s = SEL_A;
    @(posedge clk); #1;
    check("lat_base_yq", {7'b0, y_q1}, 8'h00);
    check("lat_base_y", {7'b0, y1}, 8'h00);
    @(negedge clk);
    s = SEL_B;
    #1;
    check("lat_y_now", {7'b0, y1}, 8'h01);
    check("lat_yq_hold", {7'b0, y_q1}, 8'h00);
    @(posedge clk); #1;
    check("lat_yq_edge", {7'b0, y_q1}, 8'h01);

    // Mid-operation reset pulse between edges
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_yq_w1", {7'b0, y_q1}, 8'h00);
    check("mid_rst_yq_w8", y_q8, 8'h00);
    check("mid_rst_y", {7'b0, y1}, 8'h01);
    @(posedge clk); #1;
    check("rst_held_edge", {7'b0, y_q1}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Wide data
    a8 = 8'hA5; b8 = 8'h3C; s = SEL_A;
    #1;
    check("wide_sel_a", y8, 8'hA5);
    s = SEL_B;
    #1;
    check("wide_sel_b", y8, 8'h3C);
    @(posedge clk); #1;
    check("wide_yq", y_q8, 8'h3C);
    @(negedge clk);
    s = SEL_A;
    @(posedge clk); #1;
    check("wide_yq_a", y_q8, 8'hA5);

    // Unknown select with equal inputs
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; s = 1'bx;
    #1;
    check("xsel_equal", y8, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
